bus_xfer_ctrl: RTL and testbench

//  Initiator side of the shared 16-bit tri-state register bus: sequences register-to-register

---
 rtl/bus_pkg.sv | 27 ++
 rtl/reg_sel_decode.sv | 29 ++
 rtl/bus_xfer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the register-bus transfer controller:
//                default data width, command opcodes and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int BUS_DW = 16;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_LDI  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_RD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XFER = 3'd1,
        ST_SW1  = 3'd2,
        ST_SW2  = 3'd3,
        ST_SW3  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/reg_sel_decode.sv
`default_nettype none
// ============================================================================
//  Module      : reg_sel_decode
//  Description : Register index to one-hot select decoder with enable and an
//                out-of-range flag for indices that address no register.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_sel_decode
    import bus_pkg::*;
#(
    parameter int NREG = 4,
    parameter int IW   = 2
) (
    input  logic            en,
    input  logic [IW-1:0]   idx,
    output logic [NREG-1:0] sel,
    output logic            oor
);

    // Range flag is independent of the enable so it can qualify a command
    // before any strobe is allowed to fire.
    assign oor = (32'(idx) >= NREG);

    for (genvar i = 0; i < NREG; i++) begin : g_sel
        assign sel[i] = en && (idx == IW'(i));
    end

endmodule : reg_sel_decode
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_ctrl
//  Description : Initiator for the shared tri-state register bus. Accepts
//                MOV / LDI / SWAP / RD commands and sequences one-hot
//                read/write strobes to the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int DW   = BUS_DW,
    parameter int NREG = 4,
    parameter int IW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [IW-1:0]   cmd_src,
    input  logic [IW-1:0]   cmd_dst,
    input  logic [DW-1:0]   cmd_imm,
    output logic [NREG-1:0] reg_read,
    output logic [NREG-1:0] reg_write,
    inout  wire  [DW-1:0]   bus_data,
    output logic [DW-1:0]   rd_data,
    output logic            done,
    output logic            err
);

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [IW-1:0]   src_q, src_d;
    logic [IW-1:0]   dst_q, dst_d;
    logic            bad_q, bad_d;
    logic [DW-1:0]   tmp_q, tmp_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            drv_en_q, drv_en_d;
    logic [DW-1:0]   drv_data_q, drv_data_d;

    logic [IW-1:0]   rd_idx, wr_idx;
    logic            rd_en, wr_en;
    logic            src_oor, dst_oor;

    // Strobe enables depend only on registered state and latched opcode.
    assign rd_en = ((state_q == ST_XFER) && (op_q != OP_LDI)) ||
                   (state_q == ST_SW1) || (state_q == ST_SW2);
    assign wr_en = ((state_q == ST_XFER) && (op_q != OP_RD)) ||
                   (state_q == ST_SW2) || (state_q == ST_SW3);

    // Decoder index select; in IDLE both decoders are disabled, so their range
    // flags are free to qualify the incoming command's indices.
    always_comb begin
        rd_idx = src_q;
        wr_idx = dst_q;
        if (state_q == ST_IDLE) begin
            rd_idx = cmd_src;
            wr_idx = cmd_dst;
        end else if (state_q == ST_SW2) begin
            rd_idx = dst_q;
            wr_idx = src_q;
        end
    end

    reg_sel_decode #(.NREG(NREG), .IW(IW)) u_rd_sel (
        .en  (rd_en),
        .idx (rd_idx),
        .sel (reg_read),
        .oor (src_oor)
    );

    reg_sel_decode #(.NREG(NREG), .IW(IW)) u_wr_sel (
        .en  (wr_en),
        .idx (wr_idx),
        .sel (reg_write),
        .oor (dst_oor)
    );

    // Next-state, command latch, capture and bus-drive decisions.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        src_d      = src_q;
        dst_d      = dst_q;
        bad_d      = bad_q;
        tmp_d      = tmp_q;
        rd_data_d  = rd_data_q;
        drv_en_d   = 1'b0;
        drv_data_d = drv_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    // LDI never uses src, RD never uses dst.
                    bad_d = ((cmd_op != OP_LDI) && src_oor) ||
                            ((cmd_op != OP_RD)  && dst_oor);
                    if (bad_d) begin
                        state_d = ST_FIN;
                    end else if (cmd_op == OP_SWAP) begin
                        state_d = (cmd_src == cmd_dst) ? ST_FIN : ST_SW1;
                    end else begin
                        state_d    = ST_XFER;
                        drv_en_d   = (cmd_op == OP_LDI);
                        drv_data_d = cmd_imm;
                    end
                end
            end
            ST_XFER: begin
                if (op_q == OP_RD) begin
                    rd_data_d = bus_data;
                end
                state_d = ST_FIN;
            end
            ST_SW1: begin
                tmp_d   = bus_data;
                state_d = ST_SW2;
            end
            ST_SW2: begin
                drv_en_d   = 1'b1;
                drv_data_d = tmp_q;
                state_d    = ST_SW3;
            end
            ST_SW3:  state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MOV;
            src_q      <= '0;
            dst_q      <= '0;
            bad_q      <= 1'b0;
            tmp_q      <= '0;
            rd_data_q  <= '0;
            drv_en_q   <= 1'b0;
            drv_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            bad_q      <= bad_d;
            tmp_q      <= tmp_d;
            rd_data_q  <= rd_data_d;
            drv_en_q   <= drv_en_d;
            drv_data_q <= drv_data_d;
        end
    end

    // Drive enable is only ever set for LDI-XFER and SW3, where no read
    // strobe is active, so the bus can never see two sources.
    assign bus_data  = drv_en_q ? drv_data_q : {DW{1'bz}};

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign err       = (state_q == ST_FIN) && bad_q;
    assign rd_data   = rd_data_q;

endmodule : bus_xfer_ctrl
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bus_xfer_ctrl
//  Description : Scoreboard bench for bus_xfer_ctrl with a behavioural
//                register-file model on the shared bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_xfer_ctrl;
    import bus_pkg::*;

    localparam int DW   = 16;
    localparam int NREG = 4;
    localparam int IW   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [IW-1:0]   cmd_src;
    logic [IW-1:0]   cmd_dst;
    logic [DW-1:0]   cmd_imm;
    logic [NREG-1:0] reg_read;
    logic [NREG-1:0] reg_write;
    wire  [DW-1:0]   bus_data;
    logic [DW-1:0]   rd_data;
    logic            done;
    logic            err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.DW(DW), .NREG(NREG), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_imm   (cmd_imm),
        .reg_read  (reg_read),
        .reg_write (reg_write),
        .bus_data  (bus_data),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err)
    );

    // Register file on the bus: R2 powers up to aa55, others to zero.
    logic [DW-1:0] regs [NREG];
    logic          reg_rst;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NREG; i++) begin
            if (reg_rst)           regs[i] <= (i == 2) ? 16'haa55 : 16'h0000;
            else if (reg_write[i]) regs[i] <= bus_data;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg_drv
        assign bus_data = reg_read[g] ? regs[g] : {DW{1'bz}};
    end

    // Expected per-cycle bus activity and per-command completion records.
    typedef struct {
        logic [NREG-1:0] rd;
        logic [NREG-1:0] wr;
        logic            drv;
        logic [DW-1:0]   val;
    } cyc_exp_t;

    typedef struct {
        int                        done_cyc;
        logic                      err;
        logic [NREG-1:0][DW-1:0]   regs;
        logic [DW-1:0]             rd;
    } txn_t;

    typedef struct {
        logic [1:0]    op;
        logic [IW-1:0] src;
        logic [IW-1:0] dst;
        logic [DW-1:0] imm;
        bit            abort;
        bit            gap;
    } cmd_t;

    cyc_exp_t sched [int];
    bit       busy  [int];
    txn_t     q     [$];
    cmd_t     cq    [$];

    logic [DW-1:0] mregs [NREG];
    logic [DW-1:0] rd_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NREG-1:0] oh(input int i);
        logic [NREG-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NREG-1:0][DW-1:0] pack_model();
        logic [NREG-1:0][DW-1:0] p;
        for (int i = 0; i < NREG; i++) p[i] = mregs[i];
        return p;
    endfunction

    function automatic logic [NREG-1:0][DW-1:0] pack_bus_regs();
        logic [NREG-1:0][DW-1:0] p;
        for (int i = 0; i < NREG; i++) p[i] = regs[i];
        return p;
    endfunction

    // Reference model: applies a command accepted at edge e to the register
    // model and records what the bus and handshake should look like.
    task automatic model_accept(input cmd_t c, input int e);
        int       s, d, n;
        bit       sok, dok, bad;
        cyc_exp_t x;
        txn_t     t;
        logic [DW-1:0] sv;
        s   = int'(c.src);
        d   = int'(c.dst);
        sok = (s < NREG);
        dok = (d < NREG);
        case (c.op)
            OP_MOV:  bad = !(sok && dok);
            OP_LDI:  bad = !dok;
            OP_RD:   bad = !sok;
            default: bad = !(sok && dok);
        endcase
        n = 1;
        if (!bad) begin
            case (c.op)
                OP_MOV: begin
                    x = '{rd: oh(s), wr: oh(d), drv: 1'b0, val: '0};
                    sched[e] = x;
                    mregs[d] = mregs[s];
                    n = 2;
                end
                OP_LDI: begin
                    x = '{rd: '0, wr: oh(d), drv: 1'b1, val: c.imm};
                    sched[e] = x;
                    mregs[d] = c.imm;
                    n = 2;
                end
                OP_RD: begin
                    x = '{rd: oh(s), wr: '0, drv: 1'b0, val: '0};
                    sched[e] = x;
                    rd_last = mregs[s];
                    n = 2;
                end
                default: begin
                    if (s != d) begin
                        sv = mregs[s];
                        x = '{rd: oh(s), wr: '0, drv: 1'b0, val: '0};
                        sched[e] = x;
                        x = '{rd: oh(d), wr: oh(s), drv: 1'b0, val: '0};
                        sched[e+1] = x;
                        x = '{rd: '0, wr: oh(d), drv: 1'b1, val: sv};
                        sched[e+2] = x;
                        mregs[s] = mregs[d];
                        mregs[d] = sv;
                        n = 4;
                    end
                end
            endcase
        end
        for (int k = 0; k < n; k++) busy[e+k] = 1'b1;
        t.done_cyc = e + n - 1;
        t.err      = bad;
        t.regs     = pack_model();
        t.rd       = rd_last;
        q.push_back(t);
    endtask

    // Monitor: samples just after the falling edge and checks every cycle
    // against the schedule; pops the scoreboard on completion.
    initial begin : monitor
        cyc_exp_t e;
        txn_t     t;
        bit       exp_done;
        forever begin
            @(negedge clk);
            #1;
            if (reset) continue;
            if (sched.exists(cyc)) e = sched[cyc];
            else                   e = '{rd: '0, wr: '0, drv: 1'b0, val: '0};
            chk("reg_read", 64'(reg_read), 64'(e.rd));
            chk("reg_write", 64'(reg_write), 64'(e.wr));
            chk("strobe_onehot", 64'($onehot0(reg_read) && $onehot0(reg_write)), 64'(1));
            chk("cmd_ready", 64'(cmd_ready), busy.exists(cyc) ? 64'(0) : 64'(1));
            for (int i = 0; i < NREG; i++)
                if (reg_read[i]) chk("bus_from_reg", 64'(bus_data), 64'(regs[i]));
            if (e.drv) chk("bus_driven", 64'(bus_data), 64'(e.val));
            exp_done = (q.size() != 0) && (q[0].done_cyc == cyc);
            chk("done", 64'(done), 64'(exp_done));
            if (exp_done) begin
                t = q.pop_front();
                chk("err", 64'(err), 64'(t.err));
                chk("regfile", 64'(pack_bus_regs()), 64'(t.regs));
                chk("rd_data", 64'(rd_data), 64'(t.rd));
            end else begin
                chk("err_idle", 64'(err), 64'(0));
            end
            sched.delete(cyc);
            busy.delete(cyc);
        end
    end

    // Stimulus: directed commands first, then randomized traffic.
    initial begin : driver
        cmd_t c;
        int   abort_at;
        int   guard;
        bit   gap;
        reset     = 1'b1;
        reg_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_MOV;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_imm   = '0;
        for (int i = 0; i < NREG; i++) mregs[i] = (i == 2) ? 16'haa55 : 16'h0000;
        rd_last = '0;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        reg_rst = 1'b0;
        #1;
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        chk("rst_strobes", 64'({reg_read, reg_write}), 64'(0));
        chk("rst_done_err", 64'({done, err}), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));

        cq.push_back('{op: OP_LDI,  src: 3'd6, dst: 3'd1, imm: 16'h1234, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_MOV,  src: 3'd2, dst: 3'd0, imm: 16'hffff, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_LDI,  src: 3'd0, dst: 3'd3, imm: 16'hbeef, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_SWAP, src: 3'd1, dst: 3'd3, imm: 16'h0000, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_RD,   src: 3'd3, dst: 3'd7, imm: 16'h0000, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_MOV,  src: 3'd1, dst: 3'd2, imm: 16'h0000, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_MOV,  src: 3'd0, dst: 3'd5, imm: 16'h0000, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_SWAP, src: 3'd2, dst: 3'd2, imm: 16'h0000, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_MOV,  src: 3'd3, dst: 3'd3, imm: 16'h0000, abort: 1'b0, gap: 1'b0});
        cq.push_back('{op: OP_SWAP, src: 3'd1, dst: 3'd3, imm: 16'h0000, abort: 1'b1, gap: 1'b0});
        for (int n = 0; n < 300; n++) begin
            c.op    = 2'($urandom_range(0, 3));
            c.src   = ($urandom_range(0, 9) < 8) ? IW'($urandom_range(0, 3)) : IW'($urandom_range(4, 7));
            c.dst   = ($urandom_range(0, 9) < 8) ? IW'($urandom_range(0, 3)) : IW'($urandom_range(4, 7));
            c.imm   = 16'($urandom);
            c.abort = ($urandom_range(0, 39) == 0);
            c.gap   = 1'b1;
            cq.push_back(c);
        end

        abort_at = -1;
        guard    = 0;
        while ((cq.size() != 0 || q.size() != 0) && guard < 20000) begin
            if (cyc == abort_at) begin
                reset     = 1'b1;
                cmd_valid = 1'b0;
                abort_at  = -1;
                @(negedge clk);
                q.delete();
                sched.delete();
                busy.delete();
                reset = 1'b0;
                for (int i = 0; i < NREG; i++) mregs[i] = regs[i];
                rd_last = '0;
                #1;
                chk("abort_rd_data", 64'(rd_data), 64'(0));
                chk("abort_idle", 64'({cmd_ready, done, reg_read, reg_write}),
                    64'({1'b1, 1'b0, {NREG{1'b0}}, {NREG{1'b0}}}));
                guard++;
                continue;
            end
            gap = (cq.size() != 0) && cq[0].gap && ($urandom_range(0, 3) == 0);
            if (cmd_ready && cq.size() != 0 && !gap) begin
                c = cq.pop_front();
                cmd_valid = 1'b1;
                cmd_op    = c.op;
                cmd_src   = c.src;
                cmd_dst   = c.dst;
                cmd_imm   = c.imm;
                model_accept(c, cyc + 1);
                if (c.abort && c.op == OP_SWAP) abort_at = cyc + 2;
            end else begin
                // Noise on the command inputs can never be accepted here.
                cmd_valid = cmd_ready ? 1'b0 : 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_src   = IW'($urandom_range(0, 7));
                cmd_dst   = IW'($urandom_range(0, 7));
                cmd_imm   = 16'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) chk("timeout_pending", 64'(cq.size() + q.size()), 64'(0));
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bus_xfer_ctrl
`default_nettype wire
